perceptron_trainer: RTL and testbench

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

---
 rtl/Common.sv | 53 +++++
 rtl/perceptron_trainer.sv | 142 ++++++++++++++
 tb/tb_perceptron_trainer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/Common.sv
// Shared types, constants and arithmetic helpers for the perceptron trainer.
// The dot product works modulo 2**dw, so operands need no sign extension.
package Common;

    localparam int ONE       = 1;
    localparam int MAX_VEC_W = 1024;

    typedef enum logic {HEAVISIDE_STEP} act_func_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SAMPLE,
        COMPUTE,
        UPDATE,
        EPOCH_END,
        DONE
    } trainer_state_t;

    function automatic logic [63:0] dot_product(
        input logic [MAX_VEC_W-1:0] w,
        input logic [MAX_VEC_W-1:0] x,
        input logic [63:0]          bias,
        input int unsigned          n,
        input int unsigned          dw
    );
        logic [63:0] mask;
        logic [63:0] acc;
        logic [63:0] wi;
        logic [63:0] xi;
        mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
        acc  = bias;
        for (int unsigned i = 0; i < n; i++) begin
            wi  = 64'(w >> (i * dw)) & mask;
            xi  = 64'(x >> (i * dw)) & mask;
            acc = acc + wi * xi;
        end
        return acc & mask;
    endfunction

    // sum is already reduced to dw bits; positive means nonzero with clear sign bit.
    function automatic logic activate(
        input act_func_t    f,
        input logic [63:0]  sum,
        input int unsigned  dw
    );
        logic neg;
        neg = ((sum >> (dw - 1)) & 64'd1) != 64'd0;
        if (f == HEAVISIDE_STEP)
            return !neg && (sum != 64'd0);
        return 1'b0;
    endfunction

endpackage

// File: rtl/perceptron_trainer.sv
// Single-layer perceptron trainer with Heaviside activation and registered inference.
// Optional PERCEPTRON_EARLY_STOP_EN ends training after the first error-free epoch.
module perceptron_trainer
    import Common::*;
#(
    parameter int unsigned INPUT_UNITS     = 2,
    parameter int unsigned TRAINING_INPUTS = 4,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [31:0]                   epochs,
    input  logic signed [DATA_W-1:0]      learning_rate,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic [INPUT_UNITS*DATA_W-1:0] sample_x,
    input  logic signed [DATA_W-1:0]      sample_expected,
    input  logic [INPUT_UNITS*DATA_W-1:0] infer_x,
    output logic [DATA_W-1:0]             prediction,
    output logic                          training,
    output logic                          done_training,
    output logic [15:0]                   epoch_errors,
    output logic [INPUT_UNITS*DATA_W-1:0] weights,
    output logic signed [DATA_W-1:0]      bias
);

    localparam int unsigned VEC_W = INPUT_UNITS * DATA_W;

    trainer_state_t state, next_state;

    logic [VEC_W-1:0]         w_q, x_q, w_upd;
    logic signed [DATA_W-1:0] b_q, exp_q, err, b_upd;
    logic                     pred_q, sample_pred, infer_pred, stop;
    logic [31:0]              sample_cnt, epoch_cnt;
    logic [15:0]              run_err;

    assign sample_pred = activate(HEAVISIDE_STEP,
        dot_product(MAX_VEC_W'(w_q), MAX_VEC_W'(x_q), 64'(b_q), INPUT_UNITS, DATA_W), DATA_W);
    assign infer_pred  = activate(HEAVISIDE_STEP,
        dot_product(MAX_VEC_W'(w_q), MAX_VEC_W'(infer_x), 64'(b_q), INPUT_UNITS, DATA_W), DATA_W);

    always_comb begin
        err   = exp_q - DATA_W'(pred_q);
        b_upd = b_q + learning_rate * err;
        w_upd = w_q;
        for (int unsigned i = 0; i < INPUT_UNITS; i++)
            w_upd[i*DATA_W +: DATA_W] = w_q[i*DATA_W +: DATA_W]
                                      + learning_rate * err * x_q[i*DATA_W +: DATA_W];
    end

`ifdef PERCEPTRON_EARLY_STOP_EN
    assign stop = (epoch_cnt + 32'(ONE) == epochs) || (run_err == '0);
`else
    assign stop = (epoch_cnt + 32'(ONE) == epochs);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state    = state;
        sample_ready  = 1'b0;
        training      = 1'b0;
        done_training = 1'b0;
        case (state)
            IDLE, DONE: begin
                done_training = (state == DONE);
                if (start) next_state = (epochs == '0) ? DONE : WAIT_SAMPLE;
            end
            WAIT_SAMPLE: begin
                sample_ready = 1'b1;
                training     = 1'b1;
                if (sample_valid) next_state = COMPUTE;
            end
            COMPUTE: begin
                training   = 1'b1;
                next_state = UPDATE;
            end
            UPDATE: begin
                training   = 1'b1;
                next_state = (sample_cnt == TRAINING_INPUTS) ? EPOCH_END : WAIT_SAMPLE;
            end
            EPOCH_END: begin
                training   = 1'b1;
                next_state = stop ? DONE : WAIT_SAMPLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q          <= '0;
            b_q          <= '0;
            x_q          <= '0;
            exp_q        <= '0;
            pred_q       <= 1'b0;
            sample_cnt   <= '0;
            epoch_cnt    <= '0;
            run_err      <= '0;
            epoch_errors <= '0;
            prediction   <= '0;
        end else begin
            prediction <= DATA_W'(infer_pred);
            case (state)
                IDLE, DONE: if (start) begin
                    w_q          <= '0;
                    b_q          <= '0;
                    sample_cnt   <= '0;
                    epoch_cnt    <= '0;
                    run_err      <= '0;
                    epoch_errors <= '0;
                end
                WAIT_SAMPLE: if (sample_valid) begin
                    x_q        <= sample_x;
                    exp_q      <= sample_expected;
                    sample_cnt <= sample_cnt + 32'(ONE);
                end
                COMPUTE: pred_q <= sample_pred;
                UPDATE: begin
                    w_q <= w_upd;
                    b_q <= b_upd;
                    if (err != '0 && run_err != '1) run_err <= run_err + 16'(ONE);
                end
                EPOCH_END: begin
                    epoch_errors <= run_err;
                    run_err      <= '0;
                    sample_cnt   <= '0;
                    epoch_cnt    <= epoch_cnt + 32'(ONE);
                end
                default: ;
            endcase
        end
    end

    assign weights = w_q;
    assign bias    = b_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboarded bench: the stimulus pushes model results, a monitor checks them at each done edge.
module tb_perceptron_trainer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] epochs;
    logic signed [31:0] learning_rate;
    logic        sample_valid;
    logic        sample_ready;
    logic [63:0] sample_x;
    logic signed [31:0] sample_expected;
    logic [63:0] infer_x;
    logic [31:0] prediction;
    logic        training;
    logic        done_training;
    logic [15:0] epoch_errors;
    logic [63:0] weights;
    logic signed [31:0] bias;

`ifdef PERCEPTRON_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    perceptron_trainer #(.INPUT_UNITS(2), .TRAINING_INPUTS(4), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .epochs(epochs),
        .learning_rate(learning_rate), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_x(sample_x),
        .sample_expected(sample_expected), .infer_x(infer_x),
        .prediction(prediction), .training(training),
        .done_training(done_training), .epoch_errors(epoch_errors),
        .weights(weights), .bias(bias)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w0, w1, b, errs;
        int unsigned nacc;
    } exp_t;

    exp_t exp_q[$];
    int   pred_q[$];
    int   checks = 0;
    int   passed = 0;
    int   ds0[4], ds1[4], dse[4];
    int   mw0, mw1, mb;
    bit   pred_strobe = 1'b0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Reference: plain perceptron learning rule over the stored dataset.
    task automatic model(input int lr, input int unsigned ep);
        exp_t r;
        int cnt, sum, pred, err;
        r = '{0, 0, 0, 0, 0};
        for (int unsigned e = 0; e < ep; e++) begin
            cnt = 0;
            for (int s = 0; s < 4; s++) begin
                sum  = r.b + r.w0 * ds0[s] + r.w1 * ds1[s];
                pred = (sum > 0) ? 1 : 0;
                err  = dse[s] - pred;
                r.w0 += lr * err * ds0[s];
                r.w1 += lr * err * ds1[s];
                r.b  += lr * err;
                if (err != 0) cnt++;
            end
            r.errs  = cnt;
            r.nacc += 4;
            if (EARLY && cnt == 0) break;
        end
        mw0 = r.w0; mw1 = r.w1; mb = r.b;
        exp_q.push_back(r);
    endtask

    int unsigned hs = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) hs = 0;
        else begin
            if (sample_valid && sample_ready) hs++;
            if (done_training && !prev_done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("weight0", int'(weights[31:0]), e.w0);
                    chk("weight1", int'(weights[63:32]), e.w1);
                    chk("bias", bias, e.b);
                    chk("epoch_errors", epoch_errors, e.errs);
                    chk("samples_taken", hs, e.nacc);
                end
                hs = 0;
            end
            if (pred_strobe) begin
                if (pred_q.size() == 0) chk("pred_queue_empty", 1, 0);
                else chk("prediction", prediction, pred_q.pop_front());
            end
        end
        prev_done = done_training;
    end

    task automatic pred_chk(input int x0, input int x1);
        int sum;
        @(posedge clk); #1;
        infer_x = {x1, x0};
        sum = mb + mw0 * x0 + mw1 * x1;
        pred_q.push_back((sum > 0) ? 1 : 0);
        @(posedge clk); #1 pred_strobe = 1'b1;
        @(posedge clk); #1 pred_strobe = 1'b0;
    endtask

    task automatic run(input int lr, input int unsigned ep, input int unsigned abort_after,
                       input bit stall, input bit gaps);
        int unsigned idx = 0, cyc = 0;
        bit fin = 1'b0, stalled = 1'b0;
        logic [63:0] sw;
        logic [31:0] sb;
        learning_rate = lr;
        epochs = ep;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (!fin) begin
            if (abort_after != 0 && idx == abort_after) fin = 1'b1;
            else if (done_training) fin = 1'b1;
            else if (cyc > 4000) begin
                chk("training_timeout", cyc, 0);
                fin = 1'b1;
            end else begin
                if (stall && !stalled && idx == 2 && sample_ready) begin
                    stalled = 1'b1;
                    sample_valid = 1'b0;
                    sw = weights; sb = bias;
                    for (int k = 0; k < 20; k++) begin
                        start = (k == 10);
                        @(negedge clk);
                    end
                    start = 1'b0;
                    chk("stall_weights_hi", weights[63:32], sw[63:32]);
                    chk("stall_weights_lo", weights[31:0], sw[31:0]);
                    chk("stall_bias", bias, sb);
                    chk("stall_ready", sample_ready, 1);
                    chk("stall_training", training, 1);
                end
                sample_valid    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                sample_x        = {ds1[idx % 4], ds0[idx % 4]};
                sample_expected = dse[idx % 4];
                if (sample_valid && sample_ready) idx++;
                @(negedge clk);
                cyc++;
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic set_and();
        ds0 = '{0, 0, 1, 1}; ds1 = '{0, 1, 0, 1}; dse = '{0, 0, 0, 1};
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_weights"}, weights, 0);
        chk({tag, "_bias"}, bias, 0);
        chk({tag, "_prediction"}, prediction, 0);
        chk({tag, "_epoch_errors"}, epoch_errors, 0);
        chk({tag, "_ready"}, sample_ready, 0);
        chk({tag, "_training"}, training, 0);
        chk({tag, "_done"}, done_training, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; epochs = '0; learning_rate = '0;
        sample_valid = 1'b0; sample_x = '0; sample_expected = '0;
        infer_x = {32'd1, 32'd1};
        #23;
        reset_checks("reset");
        @(negedge clk) rst_n = 1'b1;

        // Zero epochs: DONE one cycle after start, no samples requested.
        set_and();
        model(1, 0);
        learning_rate = 1; epochs = 0;
        @(negedge clk) start = 1'b1;
        chk("ep0_ready", sample_ready, 0);
        @(negedge clk) start = 1'b0;
        chk("ep0_done", done_training, 1);
        chk("ep0_ready_after", sample_ready, 0);
        chk("ep0_weights", weights, 0);

        set_and();
        model(1, 5);
        run(1, 5, 0, 1'b0, 1'b0);
        pred_chk(0, 0); pred_chk(0, 1); pred_chk(1, 0); pred_chk(1, 1);

        model(1, 10);
        run(1, 10, 0, 1'b0, 1'b1);
        pred_chk(1, 1); pred_chk(1, 0);

        ds0 = '{0, 0, 1, 1}; ds1 = '{0, 1, 0, 1}; dse = '{0, 1, 1, 0};
        model(1, 5);
        run(1, 5, 0, 1'b0, 1'b0);
        chk("xor_errors_nonzero", epoch_errors != 0, 1);

        set_and();
        model(1, 5);
        run(1, 5, 0, 1'b1, 1'b0);

        // Reset in epoch 3, then an identical rerun.
        run(1, 5, 9, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1 reset_checks("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model(1, 5);
        run(1, 5, 0, 1'b0, 1'b1);
        pred_chk(1, 1); pred_chk(0, 1);

        for (int r = 0; r < 4; r++) begin
            int lr;
            int unsigned ep;
            for (int s = 0; s < 4; s++) begin
                ds0[s] = int'($urandom_range(0, 16)) - 8;
                ds1[s] = int'($urandom_range(0, 16)) - 8;
                dse[s] = int'($urandom_range(0, 1));
            end
            lr = int'($urandom_range(1, 3));
            ep = $urandom_range(1, 4);
            model(lr, ep);
            run(lr, ep, 0, 1'b0, 1'b1);
            for (int p = 0; p < 3; p++)
                pred_chk(int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
